dp_sequencer: RTL and testbench

- Control unit that drives the 4-bit register/adder datapath: the three load strobes, the add/subtract select and the input bus.
- Accepts one command at a time over a valid/ready handshake.
- Expands each command into the cycle-by-cycle strobe sequence: load the operand register, or run N iterations of compute-then-shift accumulation.
- Sits between the board-level input logic (switches/buttons) and the datapath; its outputs connect one-to-one to the datapath's i, l1, l2, l3, f inputs.

---
 rtl/dp_sequencer.sv | 132 +++++++++++++
 tb/tb_dp_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dp_sequencer.sv
// dp_sequencer: control unit for the 4-bit register/adder datapath.
// Takes one command at a time over valid/ready and expands it into the
// cycle-by-cycle strobe sequence (l1/l2/l3/f/i) the datapath expects.
// All datapath-facing outputs decode from registered state only, so a
// change on cmd_* never reaches dp_* in the same cycle.
module dp_sequencer #(
  parameter int CNT_W = 4
) (
  input  logic             cl,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [3:0]       cmd_data,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic [3:0]       dp_i,
  output logic             dp_l1,
  output logic             dp_l2,
  output logic             dp_l3,
  output logic             dp_f,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ACC  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_COPY = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_SHIFT,
    S_COPY,
    S_DONE
  } state_t;

  // latched command fields; cnt counts remaining iterations minus one
  typedef struct packed {
    logic [1:0]       op;
    logic [3:0]       data;
    logic [CNT_W-1:0] cnt;
  } cmd_t;

  state_t state_q, state_d;
  cmd_t   cmd_q,   cmd_d;

  logic accept;

  assign cmd_ready = (state_q == S_IDLE);
  assign accept    = cmd_valid & cmd_ready;

  // next-state and command latch; the iteration counter only counts down
  // while nonzero, so an all-ones count runs the full 2^CNT_W iterations
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          cmd_d.op   = cmd_op;
          cmd_d.data = cmd_data;
          cmd_d.cnt  = cmd_cnt;
          unique case (cmd_op)
            OP_LOAD: state_d = S_LOAD;
            OP_ACC,
            OP_SUB:  state_d = S_EXEC;
            OP_COPY: state_d = S_COPY;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_LOAD:  state_d = S_DONE;
      S_EXEC:  state_d = S_SHIFT;
      S_SHIFT: begin
        if (cmd_q.cnt == '0) begin
          state_d = S_DONE;
        end else begin
          cmd_d.cnt = cmd_q.cnt - CNT_ONE;
          state_d   = S_EXEC;
        end
      end
      S_COPY:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state register; reset aborts any command in flight without a done pulse
  always_ff @(posedge cl) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
    end
  end

  // output decode from state and latched fields; one strobe at most per cycle
  always_comb begin
    dp_i  = 4'h0;
    dp_l1 = 1'b0;
    dp_l2 = 1'b0;
    dp_l3 = 1'b0;
    dp_f  = 1'b0;
    busy  = 1'b1;
    done  = 1'b0;
    unique case (state_q)
      S_IDLE: busy = 1'b0;
      S_LOAD: begin
        dp_l1 = 1'b1;
        dp_i  = cmd_q.data;
      end
      S_EXEC: begin
        dp_l3 = 1'b1;
        dp_f  = (cmd_q.op == OP_SUB);
      end
      S_SHIFT: begin
        dp_l2 = 1'b1;
        dp_f  = (cmd_q.op == OP_SUB);
      end
      S_COPY: dp_l2 = 1'b1;
      S_DONE: done  = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_dp_sequencer.sv
// Bench for dp_sequencer: a command-level trace model predicts every output
// cycle, a small datapath model shows the arithmetic effect of the strobes,
// and directed literal checks pin both.
module tb_dp_sequencer;
  localparam int CNT_W = 4;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ACC  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_COPY = 2'b11;

  logic             cl = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [3:0]       cmd_data;
  logic [CNT_W-1:0] cmd_cnt;
  logic [3:0]       dp_i;
  logic             dp_l1, dp_l2, dp_l3, dp_f, busy, done;

  dp_sequencer #(.CNT_W(CNT_W)) dut (
    .cl(cl), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt),
    .dp_i(dp_i), .dp_l1(dp_l1), .dp_l2(dp_l2), .dp_l3(dp_l3), .dp_f(dp_f),
    .busy(busy), .done(done)
  );

  always #5 cl = ~cl;

  typedef struct packed {
    logic       ready, bsy, dn, l1, l2, l3, f;
    logic [3:0] i;
  } ov_t;

  ov_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 0;
  logic [3:0] r1 = 4'd0, r2 = 4'd0, r3 = 4'd0;
  int   l2_cnt = 0, l3_cnt = 0;

  function automatic ov_t mk(input logic rdy, input logic b, input logic d,
                             input logic s1, input logic s2, input logic s3,
                             input logic ff, input logic [3:0] ii);
    ov_t v;
    v.ready = rdy; v.bsy = b; v.dn = d;
    v.l1 = s1; v.l2 = s2; v.l3 = s3; v.f = ff; v.i = ii;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // command-level model: on acceptance append the whole expected trace;
  // datapath model applies the strobes the DUT shows in the ending cycle
  initial forever begin
    @(posedge cl);
    if (dp_l1) r1 = dp_i;
    if (dp_l3) begin r3 = dp_f ? (r1 - r2) : (r1 + r2); l3_cnt++; end
    if (dp_l2) begin r2 = r3; l2_cnt++; end
    if (!rst_n) begin
      exp_q.delete();
      chk_en = 1;
    end else if (exp_q.size() == 0) begin
      if (cmd_valid) begin
        case (cmd_op)
          OP_LOAD: exp_q.push_back(mk(0,1,0,1,0,0,0,cmd_data));
          OP_COPY: exp_q.push_back(mk(0,1,0,0,1,0,0,4'h0));
          default:
            for (int it = 0; it <= int'(cmd_cnt); it++) begin
              exp_q.push_back(mk(0,1,0,0,0,1,cmd_op == OP_SUB,4'h0));
              exp_q.push_back(mk(0,1,0,0,1,0,cmd_op == OP_SUB,4'h0));
            end
        endcase
        exp_q.push_back(mk(0,1,1,0,0,0,0,4'h0));
      end
    end else begin
      void'(exp_q.pop_front());
    end
  end

  // per-cycle compare of every output against the trace model
  initial forever begin
    ov_t e, a;
    @(negedge cl);
    if (chk_en) begin
      e = (exp_q.size() != 0) ? exp_q[0] : mk(1,0,0,0,0,0,0,4'h0);
      a = mk(cmd_ready, busy, done, dp_l1, dp_l2, dp_l3, dp_f, dp_i);
      if (!rst_n) begin a.ready = 1'b0; e.ready = 1'b0; end
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL trace t=%0t got rdy/busy/done/l1/l2/l3/f/i=%b expected %b",
                 $time, a, e);
      end
    end
  end

  task automatic tick();
    @(posedge cl);
    #2;
  endtask

  // present a command and hold it until the edge that accepts it
  task automatic send(input logic [1:0] op, input logic [3:0] d, input logic [CNT_W-1:0] c);
    int b = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_cnt = c;
    while (!cmd_ready && b < 200) begin tick(); b++; end
    if (b >= 200) chk("send_timeout", 32'd1, 32'd0);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int b = 0;
    while (!cmd_ready && b < 200) begin tick(); b++; end
    if (b >= 200) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n = 1'b0; cmd_valid = 1'b1; cmd_op = OP_ACC; cmd_data = 4'd5; cmd_cnt = 4'd3;
    repeat (3) tick();
    chk("reset_outs", {dp_i, dp_l1, dp_l2, dp_l3, dp_f, busy, done}, 32'd0);
    rst_n = 1'b1; cmd_valid = 1'b0;
    tick();
    chk("reset_ready", cmd_ready, 1);

    // LOAD 3
    send(OP_LOAD, 4'd3, 4'd0);
    chk("load_l1", {dp_l1, dp_i, busy}, {1'b1, 4'd3, 1'b1});
    tick();
    chk("load_done", {done, dp_l1, busy}, 3'b101);
    tick();
    chk("load_ready", {cmd_ready, busy, done}, 3'b100);
    chk("load_r1", r1, 3);

    // ACC cnt=2: 3+0 -> 3, 6, 9
    send(OP_ACC, 4'd0, 4'd2);
    wait_idle();
    chk("acc2_r2", r2, 9);
    chk("acc2_r3", r3, 9);

    // LOAD 7, ACC cnt=3: 9 + 4*7 = 37 -> 5 mod 16
    send(OP_LOAD, 4'd7, 4'd0);
    wait_idle();
    send(OP_ACC, 4'd0, 4'd3);
    wait_idle();
    chk("acc3_wrap_r2", r2, 5);
    chk("acc3_wrap_r3", r3, 5);

    // SUB cnt=0 with R1=2, R2=5 -> 13
    send(OP_LOAD, 4'd2, 4'd0);
    wait_idle();
    chk("sub_pre_r1", r1, 2);
    send(OP_SUB, 4'd0, 4'd0);
    chk("sub_exec_f", {dp_f, dp_l3}, 2'b11);
    tick();
    chk("sub_shift_f", {dp_f, dp_l2}, 2'b11);
    tick();
    chk("sub_done_f", {dp_f, done}, 2'b01);
    tick();
    chk("sub_r3", r3, 13);
    chk("sub_r2", r2, 13);

    // busy-time cmd_valid with changing ops is ignored; COPY back-to-back
    send(OP_ACC, 4'd0, 4'd1);
    cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_data = 4'd15;
    tick(); cmd_op = OP_SUB;
    tick(); cmd_op = OP_LOAD;
    tick();
    send(OP_COPY, 4'd0, 4'd0);
    base = l2_cnt;
    wait_idle();
    chk("hs_no_load", r1, 2);
    chk("copy_one_l2", l2_cnt - base, 1);

    // all-ones count runs 16 iterations
    base = l3_cnt;
    send(OP_ACC, 4'd0, 4'd15);
    wait_idle();
    chk("cnt_max_iters", l3_cnt - base, 16);

    // reset during the 5th EXEC of a long ACC
    send(OP_ACC, 4'd0, 4'd15);
    repeat (8) tick();
    chk("mid_exec5", dp_l3, 1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_outs", {dp_l1, dp_l2, dp_l3, dp_f, busy, done}, 6'd0);
    rst_n = 1'b1;
    tick();
    chk("mid_rst_ready", {cmd_ready, done}, 2'b10);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
